operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/cpu_pkg.sv | 6 +
 rtl/operand_fetch_pkg.sv | 20 ++
 rtl/operand_fetch_if.sv | 42 ++++
 rtl/operand_fetch_scoreboard.sv | 46 ++++
 rtl/operand_fetch.sv | 86 ++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths: datapath width, register address width and register count.
package cpu_pkg;
    localparam int DATA_W   = 19;
    localparam int REG_AW   = 4;
    localparam int NUM_REGS = 16;
endpackage

// File: rtl/operand_fetch_pkg.sv
// Types shared by the operand-fetch stage, its scoreboard and its interface.
package operand_fetch_pkg;
    import cpu_pkg::*;

    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [REG_AW-1:0]   reg_t;
    typedef logic [NUM_REGS-1:0] mask_t;
    typedef logic [15:0]         cnt_t;

    typedef struct packed {
        data_t op1;
        data_t op2;
        reg_t  rd;
        logic  rd_en;
    } out_stage_t;

    function automatic mask_t reg_bit(input reg_t r);
        reg_bit = mask_t'(1) << r;
    endfunction
endpackage

// File: rtl/operand_fetch_if.sv
// Decode/regfile/writeback/issue bundle of the operand-fetch stage; slave = the stage itself.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic  in_valid;
    logic  in_ready;
    reg_t  in_rs1;
    reg_t  in_rs2;
    reg_t  in_rd;
    logic  in_rd_en;
    reg_t  read_reg1;
    reg_t  read_reg2;
    data_t read_data1;
    data_t read_data2;
    logic  wb_valid;
    reg_t  wb_reg;
    data_t wb_data;
    logic  reg_write;
    reg_t  write_reg;
    data_t write_data;
    logic  out_valid;
    logic  out_ready;
    data_t out_op1;
    data_t out_op2;
    reg_t  out_rd;
    logic  out_rd_en;
    cnt_t  stall_cnt;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_en, read_data1, read_data2,
               wb_valid, wb_reg, wb_data, out_ready,
        output in_ready, read_reg1, read_reg2, reg_write, write_reg, write_data,
               out_valid, out_op1, out_op2, out_rd, out_rd_en, stall_cnt
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_en, read_data1, read_data2,
               wb_valid, wb_reg, wb_data, out_ready,
        input  in_ready, read_reg1, read_reg2, reg_write, write_reg, write_data,
               out_valid, out_op1, out_op2, out_rd, out_rd_en, stall_cnt
    );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write mask and RAW/WAW hazard detect; mask updates one edge after accept/writeback.
// OPERAND_FETCH_BYPASS_EN: a source being written back this cycle is not a hazard.
module operand_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid_i,
    input  reg_t rs1_i,
    input  reg_t rs2_i,
    input  reg_t rd_i,
    input  logic rd_en_i,
    input  logic accept_i,
    input  logic wb_valid_i,
    input  reg_t wb_reg_i,
    output logic hazard_o
);
    mask_t pending_q;
    mask_t pending_d;
    mask_t wb_clr;
    mask_t src_block;

    always_comb begin
        wb_clr    = wb_valid_i ? reg_bit(wb_reg_i) : '0;
`ifdef OPERAND_FETCH_BYPASS_EN
        src_block = pending_q & ~wb_clr;
`else
        src_block = pending_q;
`endif
        // Destination check stays on the raw mask: forwarding only helps readers.
        hazard_o  = in_valid_i && (src_block[rs1_i] || src_block[rs2_i] ||
                                   (rd_en_i && pending_q[rd_i]));
        pending_d = pending_q & ~wb_clr;
        if (accept_i && rd_en_i) begin
            pending_d = pending_d | reg_bit(rd_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads regfile, registers operands into a 1-entry output stage (latency 1).
// Stalls on hazard or a full, unready output stage. Optional OPERAND_FETCH_BYPASS_EN forwards wb_data.
module operand_fetch
    import cpu_pkg::*, operand_fetch_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);
    logic       hazard;
    logic       accept;
    logic       out_valid_q;
    logic       out_valid_d;
    out_stage_t out_q;
    out_stage_t out_d;
    cnt_t       stall_q;
    cnt_t       stall_d;
    data_t      op1_sel;
    data_t      op2_sel;

    assign bus.read_reg1  = bus.in_rs1;
    assign bus.read_reg2  = bus.in_rs2;
    assign bus.reg_write  = bus.wb_valid;
    assign bus.write_reg  = bus.wb_reg;
    assign bus.write_data = bus.wb_data;

    assign bus.in_ready = !rst && !hazard && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    operand_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (bus.in_valid),
        .rs1_i      (bus.in_rs1),
        .rs2_i      (bus.in_rs2),
        .rd_i       (bus.in_rd),
        .rd_en_i    (bus.in_rd_en),
        .accept_i   (accept),
        .wb_valid_i (bus.wb_valid),
        .wb_reg_i   (bus.wb_reg),
        .hazard_o   (hazard)
    );

    always_comb begin
        op1_sel = bus.read_data1;
        op2_sel = bus.read_data2;
`ifdef OPERAND_FETCH_BYPASS_EN
        if (bus.wb_valid && bus.wb_reg == bus.in_rs1) op1_sel = bus.wb_data;
        if (bus.wb_valid && bus.wb_reg == bus.in_rs2) op2_sel = bus.wb_data;
`endif
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        stall_d     = stall_q;
        if (accept) begin
            out_d       = '{op1: op1_sel, op2: op2_sel, rd: bus.in_rd, rd_en: bus.in_rd_en};
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (hazard && stall_q != '1) begin
            stall_d = stall_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op1   = out_q.op1;
    assign bus.out_op2   = out_q.op2;
    assign bus.out_rd    = out_q.rd;
    assign bus.out_rd_en = out_q.rd_en;
    assign bus.stall_cnt = stall_q;
endmodule
